// File: rtl/sfp_stream_framer.sv
// Stream-side SFP frame handler: serialises a wide TX frame into AXI4-Stream beats
// and reassembles RX beats into a frame, reporting short/long/timed-out frames.
module sfp_stream_framer #(
  parameter int unsigned C_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_DATA_STREAM_BIT  = 128,
  parameter int unsigned C_RX_TIMEOUT       = 255
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_link_up,
  input  logic [C_DATA_STREAM_BIT-1:0]  i_tx_stream_data,
  input  logic                          i_sfp_start_flag,
  output logic [C_DATA_STREAM_BIT-1:0]  o_rx_stream_data,
  output logic                          o_sfp_end_flag,
  output logic                          o_tx_busy,
  output logic                          o_rx_err,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready
);

  localparam int unsigned W  = C_AXIS_TDATA_WIDTH;
  localparam int unsigned FB = C_DATA_STREAM_BIT;
  localparam int unsigned N  = FB / W;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned TW = (C_RX_TIMEOUT > 0) ? $clog2(C_RX_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);
  localparam logic [TW-1:0] TMO       = TW'(C_RX_TIMEOUT);

  // ---------------- TX ----------------
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  tx_state_t       tx_state, tx_next;
  logic [FB-1:0]   tx_shift;
  logic [CW-1:0]   tx_cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: if (i_sfp_start_flag && i_link_up) tx_next = TX_SEND;
      TX_SEND: begin
        if (!i_link_up)                                   tx_next = TX_IDLE;
        else if (m_axis_tready && (tx_cnt == LAST_BEAT))  tx_next = TX_IDLE;
      end
    endcase
  end

  // Moore decode of the state/shift registers, so outputs come straight off flops
  always_comb begin
    m_axis_tvalid = (tx_state == TX_SEND);
    o_tx_busy     = (tx_state == TX_SEND);
    m_axis_tlast  = (tx_state == TX_SEND) && (tx_cnt == LAST_BEAT);
    m_axis_tdata  = tx_shift[FB-1 -: W];
  end

  // MSB word leaves first; shift left after every accepted non-final beat
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      tx_shift <= '0;
      tx_cnt   <= '0;
    end else if (tx_state == TX_IDLE) begin
      if (i_sfp_start_flag && i_link_up) begin
        tx_shift <= i_tx_stream_data;
        tx_cnt   <= '0;
      end
    end else if (i_link_up && m_axis_tready && (tx_cnt != LAST_BEAT)) begin
      tx_shift <= tx_shift << W;
      tx_cnt   <= tx_cnt + CW'(1);
    end
  end

  // ---------------- RX ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_COLLECT, RX_DONE, RX_DISCARD} rx_state_t;

  rx_state_t       rx_state, rx_next;
  logic [FB-1:0]   rx_asm, rx_asm_nxt;
  logic [CW-1:0]   rx_cnt, rx_pos;
  logic [TW-1:0]   rx_idle;
  logic            rx_beat, rx_take, rx_at_last, rx_timeout, rx_end_d, rx_err_d;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    if (!i_link_up) begin
      rx_next = RX_IDLE;
    end else begin
      case (rx_state)
        RX_IDLE, RX_DONE, RX_COLLECT: begin
          if (rx_beat) begin
            if (s_axis_tlast)    rx_next = rx_at_last ? RX_DONE : RX_IDLE;
            else if (rx_at_last) rx_next = RX_DISCARD;
            else                 rx_next = RX_COLLECT;
          end else if (rx_state == RX_DONE) begin
            rx_next = RX_IDLE;
          end else if (rx_timeout) begin
            rx_next = RX_IDLE;
          end
        end
        RX_DISCARD: if (rx_beat && s_axis_tlast) rx_next = RX_IDLE;
      endcase
    end
  end

  // Frame position is zero outside RX_COLLECT so a new frame may start in RX_DONE
  always_comb begin
    rx_pos     = (rx_state == RX_COLLECT) ? rx_cnt : '0;
    rx_beat    = s_axis_tvalid && s_axis_tready;
    rx_take    = rx_beat && (rx_state != RX_DISCARD) && i_link_up;
    rx_at_last = (rx_pos == LAST_BEAT);
    rx_timeout = (rx_state == RX_COLLECT) && !rx_beat && (rx_idle == TMO);
    rx_end_d   = rx_take && s_axis_tlast && rx_at_last;
    rx_err_d   = (rx_take && (s_axis_tlast ^ rx_at_last)) || (i_link_up && rx_timeout);
    rx_asm_nxt = (rx_asm << W) | FB'(s_axis_tdata);
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      s_axis_tready    <= 1'b0;
      o_sfp_end_flag   <= 1'b0;
      o_rx_err         <= 1'b0;
      o_rx_stream_data <= '0;
      rx_asm           <= '0;
      rx_cnt           <= '0;
      rx_idle          <= '0;
    end else begin
      s_axis_tready  <= i_link_up;
      o_sfp_end_flag <= rx_end_d;
      o_rx_err       <= rx_err_d;
      if (rx_end_d) o_rx_stream_data <= rx_asm_nxt;
      if (!i_link_up) begin
        rx_asm <= '0;
        rx_cnt <= '0;
      end else if (rx_take) begin
        rx_asm <= rx_asm_nxt;
        rx_cnt <= rx_pos + CW'(1);
      end
      if (rx_beat || (rx_state != RX_COLLECT) || rx_timeout) rx_idle <= '0;
      else                                                   rx_idle <= rx_idle + TW'(1);
    end
  end

endmodule

// File: tb/tb_sfp_stream_framer.sv
// Bench for sfp_stream_framer: directed scenarios plus random traffic, checked every
// cycle against a queue-based frame model.
module tb_sfp_stream_framer;

  localparam int unsigned W   = 32;
  localparam int unsigned FB  = 128;
  localparam int unsigned N   = FB / W;
  localparam int unsigned TMO = 255;

  logic          i_clk, i_rst, i_link_up, i_sfp_start_flag;
  logic [FB-1:0] i_tx_stream_data, o_rx_stream_data;
  logic          o_sfp_end_flag, o_tx_busy, o_rx_err;
  logic [W-1:0]  m_axis_tdata, s_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic          s_axis_tvalid, s_axis_tlast, s_axis_tready;

  sfp_stream_framer #(.C_AXIS_TDATA_WIDTH(W), .C_DATA_STREAM_BIT(FB), .C_RX_TIMEOUT(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_link_up(i_link_up),
    .i_tx_stream_data(i_tx_stream_data), .i_sfp_start_flag(i_sfp_start_flag),
    .o_rx_stream_data(o_rx_stream_data), .o_sfp_end_flag(o_sfp_end_flag),
    .o_tx_busy(o_tx_busy), .o_rx_err(o_rx_err),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [FB-1:0] act, input logic [FB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0]  m_tx_q[$];
  logic [W-1:0]  m_rx_q[$];
  bit            m_discard;
  int            m_gap;
  logic [FB-1:0] m_frame;
  bit            e_end, e_err, e_s_tready;

  function automatic void model_reset();
    m_tx_q.delete();
    m_rx_q.delete();
    m_discard  = 1'b0;
    m_gap      = 0;
    m_frame    = '0;
    e_end      = 1'b0;
    e_err      = 1'b0;
    e_s_tready = 1'b0;
  endfunction

  // Predicts the outputs after the coming rising edge from the inputs now applied
  function automatic void model_step();
    bit beat;
    e_end = 1'b0;
    e_err = 1'b0;
    if (!i_link_up) m_tx_q.delete();
    else if (m_tx_q.size() > 0) begin
      if (m_axis_tready) void'(m_tx_q.pop_front());
    end else if (i_sfp_start_flag) begin
      for (int k = 0; k < N; k++) m_tx_q.push_back(i_tx_stream_data[FB-1-W*k -: W]);
    end

    beat = s_axis_tvalid && e_s_tready;
    if (!i_link_up) begin
      m_rx_q.delete();
      m_discard = 1'b0;
      m_gap     = 0;
    end else if (m_discard) begin
      if (beat && s_axis_tlast) m_discard = 1'b0;
    end else if (beat) begin
      m_rx_q.push_back(s_axis_tdata);
      m_gap = 0;
      if (s_axis_tlast) begin
        if (m_rx_q.size() == N) begin
          for (int k = 0; k < N; k++) m_frame[FB-1-W*k -: W] = m_rx_q[k];
          e_end = 1'b1;
        end else e_err = 1'b1;
        m_rx_q.delete();
      end else if (m_rx_q.size() == N) begin
        e_err = 1'b1;
        m_rx_q.delete();
        m_discard = 1'b1;
      end
    end else if (m_rx_q.size() > 0) begin
      m_gap++;
      if (m_gap > TMO) begin
        e_err = 1'b1;
        m_rx_q.delete();
        m_gap = 0;
      end
    end
    e_s_tready = i_link_up;
  endfunction

  // Observation of what actually went over the wire, for literal checks
  logic [W-1:0] obs_tx[$];
  bit           obs_last[$];
  int           n_end, n_err, n_busy;

  always @(negedge i_clk) begin
    if (!i_rst) model_reset();
    chk("tvalid", FB'(m_axis_tvalid), FB'(m_tx_q.size() > 0));
    chk("tx_busy", FB'(o_tx_busy), FB'(m_tx_q.size() > 0));
    if (m_tx_q.size() > 0) begin
      chk("tdata", FB'(m_axis_tdata), FB'(m_tx_q[0]));
      chk("tlast", FB'(m_axis_tlast), FB'(m_tx_q.size() == 1));
    end
    if (!i_rst) chk("rst_tdata", FB'(m_axis_tdata), '0);
    chk("s_tready", FB'(s_axis_tready), FB'(e_s_tready));
    chk("end_flag", FB'(o_sfp_end_flag), FB'(e_end));
    chk("rx_err", FB'(o_rx_err), FB'(e_err));
    chk("rx_data", o_rx_stream_data, m_frame);
    if (m_axis_tvalid && m_axis_tready) begin
      obs_tx.push_back(m_axis_tdata);
      obs_last.push_back(m_axis_tlast);
    end
    if (o_sfp_end_flag) n_end++;
    if (o_rx_err)       n_err++;
    if (o_tx_busy)      n_busy++;
    if (i_rst) model_step();
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [W-1:0] d, input logic l);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    cyc();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic start_tx(input logic [FB-1:0] f);
    i_tx_stream_data = f;
    i_sfp_start_flag = 1'b1;
    cyc();
    i_sfp_start_flag = 1'b0;
  endtask

  task automatic clear_obs();
    obs_tx.delete();
    obs_last.delete();
    n_end  = 0;
    n_err  = 0;
    n_busy = 0;
  endtask

  task automatic check_tx_beats(input string name, input logic [FB-1:0] f);
    logic [W-1:0] exp_w;
    chk({name, "_count"}, FB'(obs_tx.size()), FB'(N));
    for (int k = 0; k < N && k < obs_tx.size(); k++) begin
      exp_w = f[FB-1-W*k -: W];
      chk({name, "_beat"}, FB'(obs_tx[k]), FB'(exp_w));
      chk({name, "_last"}, FB'(obs_last[k]), FB'(k == N - 1));
    end
  endtask

  localparam logic [FB-1:0] F1 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [FB-1:0] F2 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

  initial begin
    int n;
    int link_hold;
    i_rst = 1'b0; i_link_up = 1'b1; m_axis_tready = 1'b1;
    i_sfp_start_flag = 1'b0; i_tx_stream_data = '0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0;
    clear_obs();
    cyc(3);
    chk("rst_tvalid", FB'(m_axis_tvalid), '0);
    chk("rst_busy", FB'(o_tx_busy), '0);
    chk("rst_rx_data", o_rx_stream_data, '0);
    chk("rst_s_tready", FB'(s_axis_tready), '0);
    i_rst = 1'b1;
    cyc(2);

    // Plain frame, sink always ready
    clear_obs();
    start_tx(F1);
    cyc(8);
    check_tx_beats("tx_plain", F1);
    chk("tx_busy_cycles", FB'(n_busy), FB'(4));

    // Sink toggling ready every cycle
    clear_obs();
    i_tx_stream_data = F1;
    i_sfp_start_flag = 1'b1;
    m_axis_tready    = 1'b0;
    cyc();
    i_sfp_start_flag = 1'b0;
    for (int i = 0; i < 14; i++) begin
      m_axis_tready = ~m_axis_tready;
      cyc();
    end
    m_axis_tready = 1'b1;
    cyc(2);
    check_tx_beats("tx_stall", F1);

    // Good RX frame
    clear_obs();
    send_beat(32'hAAAAAAAA, 1'b0);
    send_beat(32'hBBBBBBBB, 1'b0);
    send_beat(32'hCCCCCCCC, 1'b0);
    send_beat(32'hDDDDDDDD, 1'b1);
    cyc(3);
    chk("rx_good_data", o_rx_stream_data, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);
    chk("rx_good_end", FB'(n_end), FB'(1));
    chk("rx_good_err", FB'(n_err), '0);

    // Short frame
    clear_obs();
    send_beat(32'h1, 1'b0);
    send_beat(32'h2, 1'b0);
    send_beat(32'h3, 1'b1);
    cyc(3);
    chk("rx_short_err", FB'(n_err), FB'(1));
    chk("rx_short_end", FB'(n_end), '0);
    chk("rx_short_keep", o_rx_stream_data, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);

    // Long frame then a good one
    clear_obs();
    for (int i = 0; i < 6; i++) send_beat(W'(32'h50 + i), i == 5);
    cyc(2);
    chk("rx_long_err", FB'(n_err), FB'(1));
    chk("rx_long_end", FB'(n_end), '0);
    send_beat(32'h01010101, 1'b0);
    send_beat(32'h02020202, 1'b0);
    send_beat(32'h03030303, 1'b0);
    send_beat(32'h04040404, 1'b1);
    cyc(2);
    chk("rx_after_long", o_rx_stream_data, 128'h01010101_02020202_03030303_04040404);
    chk("rx_after_long_end", FB'(n_end), FB'(1));

    // Timeout: 256 idle cycles then the error pulse is visible on the next one
    clear_obs();
    send_beat(32'h77, 1'b0);
    send_beat(32'h88, 1'b0);
    n = 0;
    while (n < 300 && !o_rx_err) begin
      @(negedge i_clk);
      n++;
    end
    chk("rx_timeout_gap", FB'(n), FB'(257));
    cyc(45);
    chk("rx_timeout_err", FB'(n_err), FB'(1));
    chk("rx_timeout_end", FB'(n_end), '0);

    // Start while busy is ignored; start with link down is dropped
    clear_obs();
    m_axis_tready = 1'b0;
    start_tx(F1);
    start_tx(F2);
    m_axis_tready = 1'b1;
    cyc(8);
    check_tx_beats("tx_busy_ignore", F1);
    clear_obs();
    i_link_up = 1'b0;
    start_tx(F2);
    cyc(3);
    chk("tx_linkdown_beats", FB'(obs_tx.size()), '0);
    chk("tx_linkdown_busy", FB'(n_busy), '0);
    i_link_up = 1'b1;
    cyc(2);

    // Reset in the middle of a stalled frame
    m_axis_tready = 1'b0;
    start_tx(F1);
    cyc(2);
    i_rst = 1'b0;
    cyc();
    chk("rst_mid_tvalid", FB'(m_axis_tvalid), '0);
    chk("rst_mid_busy", FB'(o_tx_busy), '0);
    chk("rst_mid_rx_data", o_rx_stream_data, '0);
    i_rst = 1'b1;
    m_axis_tready = 1'b1;
    cyc(2);
    clear_obs();
    start_tx(F2);
    cyc(6);
    check_tx_beats("tx_after_rst", F2);

    // Random traffic on both directions
    link_hold = 0;
    for (int i = 0; i < 4000; i++) begin
      m_axis_tready    = ($urandom_range(0, 3) != 0);
      i_sfp_start_flag = ($urandom_range(0, 5) == 0);
      i_tx_stream_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      s_axis_tvalid    = ($urandom_range(0, 3) != 0);
      s_axis_tdata     = $urandom();
      s_axis_tlast     = ($urandom_range(0, 3) == 0);
      if (link_hold > 0) begin
        link_hold--;
        i_link_up = (link_hold == 0);
      end else if ($urandom_range(0, 199) == 0) begin
        link_hold = $urandom_range(1, 4);
        i_link_up = 1'b0;
      end
      cyc();
    end
    i_link_up = 1'b1;
    i_sfp_start_flag = 1'b0;
    s_axis_tvalid = 1'b0;
    cyc(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
